// File: rtl/bbus_pkg.sv
// Shared types and defaults for the BBUS debug-access protocol.
// The debug bus is as wide as the core's general-purpose registers.
package bbus_pkg;

  localparam int unsigned REG_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH = REG_WIDTH;
  localparam int unsigned DEF_DATA_WIDTH = REG_WIDTH;
  localparam int unsigned DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } bbus_state_e;

  // Command and response payloads at the default bus width
  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } bbus_cmd_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      err;
  } bbus_rsp_t;

  // Counter width able to hold 0..t-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/bbus_timeout.sv
// Ack-wait timer for bus masters: counts enabled cycles from a clear and
// flags the cycle in which the count reaches TIMEOUT-1.
module bbus_timeout
  import bbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned          CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a stray enable cannot wrap the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire_c = (cnt == LAST);

endmodule

// File: rtl/bbus_dbg_master.sv
// BBUS debug-access initiator: one bus transaction per accepted command,
// ack wait bounded by a timeout, result returned on a valid/ready channel.
module bbus_dbg_master
  import bbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  // debug bus
  output logic                  dbg_read_en,
  output logic                  dbg_write_en,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic [DATA_WIDTH-1:0] dbg_rdata,
  input  logic                  dbg_read_ack,
  input  logic                  dbg_write_ack
);

  bbus_state_e           state_q, state_d;
  logic                  cmd_ready_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic                  rsp_err_d;
  logic                  read_en_d;
  logic                  write_en_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  tmo_clear;
  logic                  tmo_en;
  logic                  tmo_expire_c;
  logic                  bus_ack;

  bbus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmo_clear),
    .en       (tmo_en),
    .expire_c (tmo_expire_c)
  );

  // Only the ack matching the active enable is meaningful
  assign bus_ack = (state_q == RD) ? dbg_read_ack : dbg_write_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      dbg_read_en  <= 1'b0;
      dbg_write_en <= 1'b0;
      dbg_addr     <= '0;
      dbg_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready    <= cmd_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_err      <= rsp_err_d;
      dbg_read_en  <= read_en_d;
      dbg_write_en <= write_en_d;
      dbg_addr     <= addr_d;
      dbg_wdata    <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    read_en_d   = dbg_read_en;
    write_en_d  = dbg_write_en;
    addr_d      = dbg_addr;
    wdata_d     = dbg_wdata;
    tmo_clear   = 1'b0;
    tmo_en      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        read_en_d   = 1'b0;
        write_en_d  = 1'b0;
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_data;
          tmo_clear   = 1'b1;
          read_en_d   = !cmd_write;
          write_en_d  = cmd_write;
          state_d     = cmd_write ? WR : RD;
        end
      end

      // An ack in the expiry cycle still counts as success
      RD, WR: begin
        if (bus_ack) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = (state_q == RD) ? dbg_rdata : '0;
          rsp_err_d   = 1'b0;
          read_en_d   = 1'b0;
          write_en_d  = 1'b0;
          state_d     = RSP;
        end else if (tmo_expire_c) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          read_en_d   = 1'b0;
          write_en_d  = 1'b0;
          state_d     = RSP;
        end else begin
          tmo_en = 1'b1;
        end
      end

      RSP: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        read_en_d   = 1'b0;
        write_en_d  = 1'b0;
      end
    endcase
  end

endmodule
